shot_meter: RTL and testbench

SHOT_METER -- requirements
Module: shot_meter

---
 rtl/shot_meter_pkg.sv | 22 ++
 rtl/shot_meter_tick_counter.sv | 37 +++
 rtl/shot_meter.sv | 144 ++++++++++++++
 tb/tb_shot_meter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_meter_pkg.sv
// Shared definitions for the shot meter.
//   state_t          : FSM state encoding (READY / COOLDOWN / EMPTY)
//   LAMP_ON          : lamp value used to build the full-magazine display
//   BLINK_PHASE_INIT : blink phase on reset and on entry to EMPTY
//   count_width()    : counter width for a tick counter of a given limit
package shot_meter_pkg;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_EMPTY    = 2'd2
    } state_t;

    localparam logic LAMP_ON          = 1'b1;
    localparam logic BLINK_PHASE_INIT = 1'b0;

    // A limit of 1 still needs a one-bit register.
    function automatic int unsigned count_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/shot_meter_tick_counter.sv
// Free-running tick counter with synchronous clear.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   clear  : forces the count to zero on the next edge
//   enable : advance the count by one per cycle
//   done   : high in the enabled cycle that completes LIMIT ticks;
//            the count wraps to zero on that edge
module tick_counter
    import shot_meter_pkg::*;
#(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned   CW   = count_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign done = enable && (count == LAST);

endmodule

// File: rtl/shot_meter.sv
// Shot meter: counts shots from a magazine, enforces a cooldown between
// shots, and drives a thermometer lamp display that blinks when empty.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   trigger    : trigger level (synchronous to clk); rising edge shoots
//   reload     : level; refills the magazine in any cycle it is high
//   lamps      : indicator lamps, 1 = lit
//   fire       : one-cycle pulse per accepted shot
//   empty      : high while the magazine holds zero shots
//   shots_left : remaining shot count
module shot_meter
    import shot_meter_pkg::*;
#(
    parameter int unsigned NUM_SHOTS  = 3,
    parameter int unsigned COOLDOWN   = 25_000_000,
    parameter int unsigned BLINK_HALF = 12_500_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             trigger,
    input  logic                             reload,
    output logic [NUM_SHOTS-1:0]             lamps,
    output logic                             fire,
    output logic                             empty,
    output logic [$clog2(NUM_SHOTS+1)-1:0]   shots_left
);

    localparam int unsigned          SW          = $clog2(NUM_SHOTS + 1);
    localparam logic [SW-1:0]        FULL        = SW'(NUM_SHOTS);
    localparam logic [NUM_SHOTS-1:0] LAMPS_RESET = {NUM_SHOTS{LAMP_ON}};

    state_t                 state;
    state_t                 state_n;
    logic [SW-1:0]          shots_n;
    logic                   phase;
    logic                   phase_n;
    logic                   trig_q;
    logic                   trig_edge;
    logic                   shoot;
    logic                   fire_n;
    logic                   empty_n;
    logic [NUM_SHOTS-1:0]   lamps_n;
    logic                   cool_clear;
    logic                   cool_done;
    logic                   blink_clear;
    logic                   blink_done;

    assign trig_edge = trigger && !trig_q;
    assign shoot     = !reload && (state == ST_READY) && trig_edge
                       && (shots_left != '0);

    // Each counter is held at zero outside its own state, so entering the
    // state starts it from zero; reload clears both immediately.
    assign cool_clear  = reload || (state != ST_COOLDOWN);
    assign blink_clear = reload || (state != ST_EMPTY);

    tick_counter #(.LIMIT(COOLDOWN)) u_cooldown (
        .clk    (clk),
        .rst    (reset),
        .clear  (cool_clear),
        .enable (state == ST_COOLDOWN),
        .done   (cool_done)
    );

    tick_counter #(.LIMIT(BLINK_HALF)) u_blink (
        .clk    (clk),
        .rst    (reset),
        .clear  (blink_clear),
        .enable (state == ST_EMPTY),
        .done   (blink_done)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_READY;
            shots_left <= FULL;
            phase      <= BLINK_PHASE_INIT;
            trig_q     <= 1'b0;
            lamps      <= LAMPS_RESET;
            fire       <= 1'b0;
            empty      <= 1'b0;
        end else begin
            state      <= state_n;
            shots_left <= shots_n;
            phase      <= phase_n;
            trig_q     <= trigger;
            lamps      <= lamps_n;
            fire       <= fire_n;
            empty      <= empty_n;
        end
    end

    // Next-state logic. Reload overrides everything, including a trigger
    // edge in the same cycle.
    always_comb begin
        state_n = state;
        shots_n = shots_left;
        phase_n = phase;
        if (reload) begin
            state_n = ST_READY;
            shots_n = FULL;
            phase_n = BLINK_PHASE_INIT;
        end else begin
            case (state)
                ST_READY: begin
                    if (shoot) begin
                        shots_n = shots_left - SW'(1);
                        state_n = (shots_left == SW'(1)) ? ST_EMPTY : ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_done) begin
                        state_n = ST_READY;
                    end
                end
                ST_EMPTY: begin
                    if (blink_done) begin
                        phase_n = !phase;
                    end
                end
                default: begin
                    state_n = ST_READY;
                end
            endcase
        end
    end

    // Output values for the next cycle, derived from the next state so that
    // every output is registered yet reflects its cause one cycle later.
    always_comb begin
        fire_n  = shoot;
        empty_n = (state_n == ST_EMPTY);
        lamps_n = '0;
        if (state_n == ST_EMPTY) begin
            lamps_n = {NUM_SHOTS{phase_n}};
        end else begin
            for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
                lamps_n[i] = (SW'(i) < shots_n);
            end
        end
    end

endmodule

// File: tb/tb_shot_meter.sv
module tb_shot_meter;

    localparam int unsigned NS = 3;
    localparam int unsigned CD = 4;
    localparam int unsigned BH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic       reload;
    logic [2:0] lamps;
    logic       fire;
    logic       empty;
    logic [1:0] shots_left;

    int checks = 0;
    int errors = 0;

    // Reference model: shot bookkeeping by clock-edge index.
    int n;
    int m_shots;
    int m_shot_edge;
    int m_empty_since;
    bit m_prev;
    bit m_fire;

    // Directed first-magazine sequence: trigger per cycle, expected
    // {lamps, fire, empty, shots_left} after that edge.
    localparam bit         SEQ_T [17] = '{1,0,1,0,0,1,0,0,0,0,1,0,0,0,0,1,0};
    localparam logic [6:0] SEQ_E [17] = '{
        7'b011_1_0_10, 7'b011_0_0_10, 7'b011_0_0_10, 7'b011_0_0_10,
        7'b011_0_0_10, 7'b001_1_0_01, 7'b001_0_0_01, 7'b001_0_0_01,
        7'b001_0_0_01, 7'b001_0_0_01, 7'b000_1_1_00, 7'b000_0_1_00,
        7'b111_0_1_00, 7'b111_0_1_00, 7'b000_0_1_00, 7'b000_0_1_00,
        7'b111_0_1_00
    };

    shot_meter #(
        .NUM_SHOTS  (NS),
        .COOLDOWN   (CD),
        .BLINK_HALF (BH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .reload     (reload),
        .lamps      (lamps),
        .fire       (fire),
        .empty      (empty),
        .shots_left (shots_left)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        n             = 0;
        m_shots       = NS;
        m_shot_edge   = -1000;
        m_empty_since = -1;
        m_prev        = 1'b0;
        m_fire        = 1'b0;
    endfunction

    function automatic void model_edge(input bit t, input bit r);
        n++;
        m_fire = 1'b0;
        if (r) begin
            m_shots       = NS;
            m_shot_edge   = -1000;
            m_empty_since = -1;
        end else if (t && !m_prev && m_shots > 0 && n > m_shot_edge + int'(CD)) begin
            m_fire      = 1'b1;
            m_shots     = m_shots - 1;
            m_shot_edge = n;
            if (m_shots == 0) m_empty_since = n;
        end
        m_prev = t;
    endfunction

    function automatic logic [6:0] model_vec();
        logic [2:0] l;
        if (m_shots == 0)
            l = (((n - m_empty_since) / int'(BH)) % 2 == 1) ? 3'b111 : 3'b000;
        else
            l = 3'((1 << m_shots) - 1);
        return {l, m_fire, (m_shots == 0), 2'(m_shots)};
    endfunction

    task automatic step(input logic t, input logic r);
        trigger = t;
        reload  = r;
        @(posedge clk);
        model_edge(t, r);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset   = 1'b1;
        trigger = 1'b0;
        reload  = 1'b0;
        #2;
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b111_0_0_11) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", got, 7'b111_0_0_11);
        end
        repeat (3) @(posedge clk);
        #1;
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b111_0_0_11) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", got, 7'b111_0_0_11);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_first_magazine();
        logic [6:0] got;
        for (int i = 0; i < 17; i++) begin
            step(SEQ_T[i], 1'b0);
            got = {lamps, fire, empty, shots_left};
            checks++;
            if (got !== SEQ_E[i]) begin
                errors++;
                $display("FAIL first_magazine[%0d]: got %b expected %b", i, got, SEQ_E[i]);
            end
        end
    endtask

    task automatic test_reload_in_empty();
        logic [6:0] got;
        step(1'b1, 1'b1);
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b111_0_0_11) begin
            errors++;
            $display("FAIL reload_beats_edge: got %b expected %b", got, 7'b111_0_0_11);
        end
        step(1'b0, 1'b0);
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b111_0_0_11) begin
            errors++;
            $display("FAIL after_reload: got %b expected %b", got, 7'b111_0_0_11);
        end
    endtask

    task automatic test_held_trigger();
        logic [6:0] got;
        int fires;
        step(1'b1, 1'b0);
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b011_1_0_10) begin
            errors++;
            $display("FAIL held_first_shot: got %b expected %b", got, 7'b011_1_0_10);
        end
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (fire) fires++;
        end
        checks++;
        if (fires != 0) begin
            errors++;
            $display("FAIL held_no_fire: got %0d fires expected 0", fires);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b001_1_0_01) begin
            errors++;
            $display("FAIL repress_fires: got %b expected %b", got, 7'b001_1_0_01);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b111_0_0_11) begin
            errors++;
            $display("FAIL held_reload: got %b expected %b", got, 7'b111_0_0_11);
        end
    endtask

    task automatic test_reload_held();
        logic [6:0] got;
        for (int i = 0; i < 6; i++) begin
            step(logic'(i % 2 == 0), 1'b1);
            got = {lamps, fire, empty, shots_left};
            checks++;
            if (got !== 7'b111_0_0_11) begin
                errors++;
                $display("FAIL reload_held[%0d]: got %b expected %b", i, got, 7'b111_0_0_11);
            end
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_cooldown();
        logic [6:0] got;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b111_0_0_11) begin
            errors++;
            $display("FAIL reset_mid_cooldown: got %b expected %b", got, 7'b111_0_0_11);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        got = {lamps, fire, empty, shots_left};
        checks++;
        if (got !== 7'b011_1_0_10) begin
            errors++;
            $display("FAIL fire_after_reset: got %b expected %b", got, 7'b011_1_0_10);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] got;
        logic [6:0] exp;
        logic t;
        logic r;
        t = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) t = ~t;
            r = ($urandom_range(0, 29) == 0);
            step(t, r);
            got = {lamps, fire, empty, shots_left};
            exp = model_vec();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_magazine();
        test_reload_in_empty();
        test_held_trigger();
        test_reload_held();
        test_reset_mid_cooldown();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
